// File: rtl/traffic_pkg.sv
// Shared types for the N-road traffic controller family: phase encoding and lamp levels.
package traffic_pkg;

    typedef enum logic [1:0] {
        PH_ALLRED = 2'b00,
        PH_GREEN  = 2'b01,
        PH_YELLOW = 2'b10
    } phase_t;

    localparam logic LAMP_ON  = 1'b1;
    localparam logic LAMP_OFF = 1'b0;

endpackage

// File: rtl/traffic_ctrl_n_rr_pick.sv
// Combinational round-robin picker: first requester after i_last_idx, wrapping,
// with i_last_idx itself considered last.
module rr_pick #(
    parameter  int NUM_ROADS = 3,
    localparam int IDX_W     = (NUM_ROADS > 1) ? $clog2(NUM_ROADS) : 1
) (
    input  logic [NUM_ROADS-1:0] i_req,
    input  logic [IDX_W-1:0]     i_last_idx,
    output logic                 o_valid,
    output logic [IDX_W-1:0]     o_next_idx
);

    int               w_cand;
    logic [IDX_W-1:0] w_idx;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        o_valid    = 1'b0;
        o_next_idx = i_last_idx;
        w_cand     = 0;
        w_idx      = '0;
        for (int k = NUM_ROADS; k >= 1; k--) begin
            w_cand = (int'(i_last_idx) + k) % NUM_ROADS;
            w_idx  = IDX_W'(w_cand);
            if (i_req[w_idx]) begin
                o_valid    = 1'b1;
                o_next_idx = w_idx;
            end
        end
    end

endmodule

// File: rtl/traffic_ctrl_n.sv
// Demand-actuated N-road traffic-light controller; one road green at a time,
// phase durations counted in tick_en strobes.
//
//   state      | meaning
//   PH_ALLRED  | clearance; every road red, grant decided at expiry
//   PH_GREEN   | active_road green, all others red
//   PH_YELLOW  | active_road yellow, all others red
module traffic_ctrl_n
    import traffic_pkg::*;
#(
    parameter  int NUM_ROADS    = 3,
    parameter  int GREEN_TICKS  = 5,
    parameter  int YELLOW_TICKS = 2,
    parameter  int ALLRED_TICKS = 1,
    parameter  int CNT_W        = 8,
    localparam int IDX_W        = (NUM_ROADS > 1) ? $clog2(NUM_ROADS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick_en,
    input  logic [NUM_ROADS-1:0] demand,
    output logic [NUM_ROADS-1:0] red,
    output logic [NUM_ROADS-1:0] yellow,
    output logic [NUM_ROADS-1:0] green,
    output logic [IDX_W-1:0]     active_road,
    output logic [1:0]           phase
);

    localparam logic [CNT_W-1:0] LD_GREEN  = CNT_W'(GREEN_TICKS - 1);
    localparam logic [CNT_W-1:0] LD_YELLOW = CNT_W'(YELLOW_TICKS - 1);
    localparam logic [CNT_W-1:0] LD_ALLRED = CNT_W'(ALLRED_TICKS - 1);
    localparam logic [IDX_W-1:0] LAST_ROAD = IDX_W'(NUM_ROADS - 1);

    phase_t             r_phase;
    logic [CNT_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   r_active;
    logic               w_pick_valid;
    logic [IDX_W-1:0]   w_pick_idx;

    rr_pick #(.NUM_ROADS(NUM_ROADS)) u_pick (
        .i_req      (demand),
        .i_last_idx (r_active),
        .o_valid    (w_pick_valid),
        .o_next_idx (w_pick_idx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_phase  <= PH_ALLRED;
            r_cnt    <= LD_ALLRED;
            r_active <= LAST_ROAD;
        end else begin
            case (r_phase)
                PH_ALLRED: begin
                    if (tick_en) begin
                        if (r_cnt != '0) begin
                            r_cnt <= r_cnt - 1'b1;
                        end else if (w_pick_valid) begin
                            r_phase  <= PH_GREEN;
                            r_cnt    <= LD_GREEN;
                            r_active <= w_pick_idx;
                        end
                    end
                end
                PH_GREEN: begin
                    if (tick_en) begin
                        if (r_cnt != '0) begin
                            r_cnt <= r_cnt - 1'b1;
                        end else begin
                            r_phase <= PH_YELLOW;
                            r_cnt   <= LD_YELLOW;
                        end
                    end
                end
                PH_YELLOW: begin
                    if (tick_en) begin
                        if (r_cnt != '0) begin
                            r_cnt <= r_cnt - 1'b1;
                        end else begin
                            r_phase <= PH_ALLRED;
                            r_cnt   <= LD_ALLRED;
                        end
                    end
                end
                // Corrupted encoding recovers on the next edge regardless of tick_en.
                default: begin
                    r_phase <= PH_ALLRED;
                    r_cnt   <= LD_ALLRED;
                end
            endcase
        end
    end

    always_comb begin
        red    = {NUM_ROADS{LAMP_ON}};
        yellow = {NUM_ROADS{LAMP_OFF}};
        green  = {NUM_ROADS{LAMP_OFF}};
        case (r_phase)
            PH_GREEN: begin
                red[r_active]   = LAMP_OFF;
                green[r_active] = LAMP_ON;
            end
            PH_YELLOW: begin
                red[r_active]    = LAMP_OFF;
                yellow[r_active] = LAMP_ON;
            end
            default: ;
        endcase
    end

    assign active_road = r_active;
    assign phase       = r_phase;

endmodule

// File: tb/tb_traffic_ctrl_n.sv
// Directed and randomised bench for traffic_ctrl_n (3 roads, green 4, yellow 2, all-red 1).
module tb_traffic_ctrl_n;

    localparam logic [1:0] A = 2'd0;
    localparam logic [1:0] G = 2'd1;
    localparam logic [1:0] Y = 2'd2;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick_en;
    logic [2:0] demand;
    logic [2:0] red, yellow, green;
    logic [1:0] active_road;
    logic [1:0] phase;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0] dem;
        logic       tick;
        logic [1:0] ph;
        logic [1:0] road;
        int         n;
    } vec_t;

    vec_t vecs[$];

    traffic_ctrl_n #(
        .NUM_ROADS(3), .GREEN_TICKS(4), .YELLOW_TICKS(2), .ALLRED_TICKS(1), .CNT_W(8)
    ) dut (
        .clk(clk), .reset(reset), .tick_en(tick_en), .demand(demand),
        .red(red), .yellow(yellow), .green(green),
        .active_road(active_road), .phase(phase)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [1:0] eph, input logic [1:0] eroad);
        logic [2:0] er, ey, eg;
        er = 3'b111;
        ey = 3'b000;
        eg = 3'b000;
        if (eph == G) begin
            er[eroad] = 1'b0;
            eg[eroad] = 1'b1;
        end else if (eph == Y) begin
            er[eroad] = 1'b0;
            ey[eroad] = 1'b1;
        end
        checks++;
        if (phase !== eph || active_road !== eroad || red !== er || yellow !== ey || green !== eg) begin
            errors++;
            $display("FAIL %s @%0t: got ph=%0d road=%0d r=%b y=%b g=%b, want ph=%0d road=%0d r=%b y=%b g=%b",
                     nm, $time, phase, active_road, red, yellow, green, eph, eroad, er, ey, eg);
        end
    endtask

    task automatic step(input logic [2:0] dem, input logic tk);
        demand  = dem;
        tick_en = tk;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] eph, erd;
        int         nonred;

        // 1: full demand rotation 0,1,2,0
        vecs.push_back('{3'b111, 1'b1, G, 2'd0, 4});
        vecs.push_back('{3'b111, 1'b1, Y, 2'd0, 2});
        vecs.push_back('{3'b111, 1'b1, A, 2'd0, 1});
        vecs.push_back('{3'b111, 1'b1, G, 2'd1, 4});
        vecs.push_back('{3'b111, 1'b1, Y, 2'd1, 2});
        vecs.push_back('{3'b111, 1'b1, A, 2'd1, 1});
        vecs.push_back('{3'b111, 1'b1, G, 2'd2, 4});
        vecs.push_back('{3'b111, 1'b1, Y, 2'd2, 2});
        vecs.push_back('{3'b111, 1'b1, A, 2'd2, 1});
        vecs.push_back('{3'b111, 1'b1, G, 2'd0, 4});
        vecs.push_back('{3'b111, 1'b1, Y, 2'd0, 2});
        vecs.push_back('{3'b111, 1'b1, A, 2'd0, 1});
        // 2: demand 101 alternates 2,0,2
        vecs.push_back('{3'b101, 1'b1, G, 2'd2, 4});
        vecs.push_back('{3'b101, 1'b1, Y, 2'd2, 2});
        vecs.push_back('{3'b101, 1'b1, A, 2'd2, 1});
        vecs.push_back('{3'b101, 1'b1, G, 2'd0, 4});
        vecs.push_back('{3'b101, 1'b1, Y, 2'd0, 2});
        vecs.push_back('{3'b101, 1'b1, A, 2'd0, 1});
        vecs.push_back('{3'b101, 1'b1, G, 2'd2, 4});
        vecs.push_back('{3'b101, 1'b1, Y, 2'd2, 2});
        vecs.push_back('{3'b101, 1'b1, A, 2'd2, 1});
        // 3: no demand holds all-red, then immediate grant, tick freeze, self re-grant
        vecs.push_back('{3'b000, 1'b1, A, 2'd2, 6});
        vecs.push_back('{3'b010, 1'b1, G, 2'd1, 1});
        vecs.push_back('{3'b010, 1'b0, G, 2'd1, 5});
        vecs.push_back('{3'b010, 1'b1, G, 2'd1, 3});
        vecs.push_back('{3'b010, 1'b1, Y, 2'd1, 2});
        vecs.push_back('{3'b010, 1'b1, A, 2'd1, 1});
        vecs.push_back('{3'b010, 1'b1, G, 2'd1, 4});
        vecs.push_back('{3'b010, 1'b1, Y, 2'd1, 2});
        vecs.push_back('{3'b010, 1'b1, A, 2'd1, 1});

        reset   = 1'b1;
        demand  = 3'b111;
        tick_en = 1'b1;
        #1;
        check("reset_state", A, 2'd2);
        repeat (2) @(posedge clk);
        #1;
        check("reset_held", A, 2'd2);
        reset = 1'b0;

        foreach (vecs[v]) begin
            for (int j = 0; j < vecs[v].n; j++) begin
                step(vecs[v].dem, vecs[v].tick);
                check($sformatf("vec%0d.%0d", v, j), vecs[v].ph, vecs[v].road);
            end
        end

        // 4: tick_en every third clock stretches every phase threefold
        for (int i = 0; i < 24; i++) begin
            step(3'b111, (i % 3) == 2);
            if (i < 2)       begin eph = A; erd = 2'd1; end
            else if (i < 14) begin eph = G; erd = 2'd2; end
            else if (i < 20) begin eph = Y; erd = 2'd2; end
            else if (i < 23) begin eph = A; erd = 2'd2; end
            else             begin eph = G; erd = 2'd0; end
            check($sformatf("slow_tick%0d", i), eph, erd);
        end

        // 5: async reset in the middle of yellow on road 1
        for (int i = 0; i < 11; i++) begin
            step(3'b111, 1'b1);
            if (i < 3)       begin eph = G; erd = 2'd0; end
            else if (i < 5)  begin eph = Y; erd = 2'd0; end
            else if (i < 6)  begin eph = A; erd = 2'd0; end
            else if (i < 10) begin eph = G; erd = 2'd1; end
            else             begin eph = Y; erd = 2'd1; end
            check($sformatf("pre_reset%0d", i), eph, erd);
        end
        #3 reset = 1'b1;
        #1;
        check("async_reset", A, 2'd2);
        @(posedge clk);
        #1;
        check("reset_mid", A, 2'd2);
        reset = 1'b0;
        step(3'b111, 1'b1);
        check("after_reset_grant", G, 2'd0);

        // 6: random demand / tick_en, structural lamp invariants
        for (int i = 0; i < 3000; i++) begin
            step(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            nonred = 0;
            checks++;
            for (int k = 0; k < 3; k++) begin
                if (!red[k]) nonred++;
            end
            if (nonred > 1 || phase == 2'b11 || !$onehot({red[0], yellow[0], green[0]})
                || !$onehot({red[1], yellow[1], green[1]}) || !$onehot({red[2], yellow[2], green[2]})) begin
                errors++;
                $display("FAIL rand_invariant%0d: got ph=%0d r=%b y=%b g=%b, want one lamp/road, <=1 non-red, ph!=3",
                         i, phase, red, yellow, green);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
